// File: rtl/mor1kx_rf_pkg.sv
// -----------------------------------------------------------------------------
// mor1kx_rf_pkg
// Shared definitions for the multi-port register-file RAM:
//   - rf_state_e : clear sequencer states (RESET -> CLEAR -> RUN)
//   - slice_lo   : low bit index of slice idx in a packed vector of
//                  equally sized fields (address / data buses)
// -----------------------------------------------------------------------------
package mor1kx_rf_pkg;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2
    } rf_state_e;

    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/mor1kx_rf_tap.sv
// -----------------------------------------------------------------------------
// mor1kx_rf_tap
// One snoop tap: mirrors every accepted write to TAP_ADDR into a register and
// pulses a strobe for the cycle after the write.
// Ports:
//   clk        in   clock (rising edge)
//   rst_n      in   synchronous active-low reset
//   wr_acc_i   in   write accepted this cycle
//   waddr_i    in   write address
//   din_i      in   write data
//   tap_data_o out  last value written to TAP_ADDR
//   tap_stb_o  out  one-cycle update strobe
// -----------------------------------------------------------------------------
module mor1kx_rf_tap #(
    parameter int                    ADDR_WIDTH = 5,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] TAP_ADDR   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_acc_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    output logic [DATA_WIDTH-1:0] tap_data_o,
    output logic                  tap_stb_o
);

    logic [DATA_WIDTH-1:0] tap_data_q;
    logic                  tap_stb_q;
    logic                  hit;

    assign hit = wr_acc_i && (waddr_i == TAP_ADDR);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tap_data_q <= '0;
            tap_stb_q  <= 1'b0;
        end else begin
            tap_stb_q <= hit;
            if (hit) begin
                tap_data_q <= din_i;
            end
        end
    end

    assign tap_data_o = tap_data_q;
    assign tap_stb_o  = tap_stb_q;

endmodule

// File: rtl/mor1kx_rf_dpram_mp.sv
// -----------------------------------------------------------------------------
// mor1kx_rf_dpram_mp
// Single-clock register-file RAM: one write port, NUM_RD registered read ports
// with individual write-to-read bypass, NUM_TAPS snoop taps, and an optional
// post-reset clear sequencer that zeroes the array.
// Ports:
//   clk       in   clock (rising edge)
//   rst_n     in   synchronous active-low reset
//   raddr     in   packed read addresses, port p at slice p
//   re        in   per-port read enable
//   waddr     in   write address
//   we        in   write enable
//   din       in   write data
//   dout      out  packed per-port read data, port p at slice p
//   tap_data  out  packed tap register values, tap k at slice k
//   tap_stb   out  per-tap one-cycle update strobe
//   busy      out  clear sequencer active; accesses ignored
// -----------------------------------------------------------------------------
module mor1kx_rf_dpram_mp
    import mor1kx_rf_pkg::*;
#(
    parameter int ADDR_WIDTH     = 5,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_RD         = 2,
    parameter int ENABLE_BYPASS  = 1,
    parameter int NUM_TAPS       = 2,
    parameter logic [((NUM_TAPS > 0) ? NUM_TAPS : 1)*ADDR_WIDTH-1:0] TAP_ADDRS = {5'd20, 5'd9},
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                                                clk,
    input  logic                                                rst_n,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]                        raddr,
    input  logic [NUM_RD-1:0]                                   re,
    input  logic [ADDR_WIDTH-1:0]                               waddr,
    input  logic                                                we,
    input  logic [DATA_WIDTH-1:0]                               din,
    output logic [NUM_RD*DATA_WIDTH-1:0]                        dout,
    output logic [((NUM_TAPS > 0) ? NUM_TAPS : 1)*DATA_WIDTH-1:0] tap_data,
    output logic [((NUM_TAPS > 0) ? NUM_TAPS : 1)-1:0]          tap_stb,
    output logic                                                busy
);

    localparam int                  DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CNT_LAST = (ADDR_WIDTH+1)'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH+1)'(1);

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    rf_state_e             state_q;
    logic [ADDR_WIDTH:0]   cnt_q;
    logic                  busy_q;
    logic                  wr_acc;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_wa;
    logic [DATA_WIDTH-1:0] mem_wd;

    // Clear sequencer; the counter has one spare bit so it never wraps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RESET;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_RESET: begin
                    if (CLEAR_ON_RESET != 0) begin
                        state_q <= ST_CLEAR;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    cnt_q <= cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign wr_acc = rst_n && we && !busy_q;

    // The clear sequencer owns the write port while it runs.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = waddr;
        mem_wd = din;
        if (rst_n && (state_q == ST_CLEAR)) begin
            mem_we = 1'b1;
            mem_wa = cnt_q[ADDR_WIDTH-1:0];
            mem_wd = '0;
        end else if (wr_acc) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    // Read ports: array read returns pre-write data; the bypass register
    // supplies the same-cycle write value instead.
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic                  rd_acc;
        logic                  byp_hit;
        logic [DATA_WIDTH-1:0] rdata_q;
        logic [DATA_WIDTH-1:0] din_r_q;
        logic                  byp_q;

        assign ra      = raddr[slice_lo(p, ADDR_WIDTH) +: ADDR_WIDTH];
        assign rd_acc  = rst_n && re[p] && !busy_q;
        assign byp_hit = (ENABLE_BYPASS != 0) && rd_acc && wr_acc && (waddr == ra);

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                rdata_q <= '0;
                din_r_q <= '0;
                byp_q   <= 1'b0;
            end else if (rd_acc) begin
                rdata_q <= mem[ra];
                byp_q   <= byp_hit;
                if (byp_hit) begin
                    din_r_q <= din;
                end
            end
        end

        assign dout[slice_lo(p, DATA_WIDTH) +: DATA_WIDTH] = byp_q ? din_r_q : rdata_q;
    end

    if (NUM_TAPS > 0) begin : g_taps
        for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
            mor1kx_rf_tap #(
                .ADDR_WIDTH (ADDR_WIDTH),
                .DATA_WIDTH (DATA_WIDTH),
                .TAP_ADDR   (TAP_ADDRS[slice_lo(k, ADDR_WIDTH) +: ADDR_WIDTH])
            ) u_tap (
                .clk        (clk),
                .rst_n      (rst_n),
                .wr_acc_i   (wr_acc),
                .waddr_i    (waddr),
                .din_i      (din),
                .tap_data_o (tap_data[slice_lo(k, DATA_WIDTH) +: DATA_WIDTH]),
                .tap_stb_o  (tap_stb[k])
            );
        end
    end else begin : g_no_taps
        assign tap_data = '0;
        assign tap_stb  = '0;
    end

endmodule

// File: tb/tb_mor1kx_rf_dpram_mp.sv
// -----------------------------------------------------------------------------
// tb_mor1kx_rf_dpram_mp
// Self-checking bench for mor1kx_rf_dpram_mp with default parameters
// (32 x 32, two read ports, taps at addresses 9 and 20, clear on reset).
// -----------------------------------------------------------------------------
module tb_mor1kx_rf_dpram_mp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  raddr;
    logic [1:0]  re;
    logic [4:0]  waddr;
    logic        we;
    logic [31:0] din;
    logic [63:0] dout;
    logic [63:0] tap_data;
    logic [1:0]  tap_stb;
    logic        busy;

    always #5 clk = ~clk;

    mor1kx_rf_dpram_mp dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .raddr    (raddr),
        .re       (re),
        .waddr    (waddr),
        .we       (we),
        .din      (din),
        .dout     (dout),
        .tap_data (tap_data),
        .tap_stb  (tap_stb),
        .busy     (busy)
    );

    typedef struct {
        logic [63:0] dout;
        logic [63:0] tap;
        logic [1:0]  stb;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mdl [32];
    logic [31:0] exp_do [2];
    logic [31:0] exp_tap [2];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus (called at posedge+1), predict the outputs
    // from the reference model, then compare after the next edge.
    task automatic step(input logic w, input logic [4:0] wa, input logic [31:0] d,
                        input logic [1:0] r, input logic [4:0] ra0, input logic [4:0] ra1);
        exp_t       e;
        logic [4:0] ra [2];
        ra[0] = ra0;
        ra[1] = ra1;
        we    = w;
        waddr = wa;
        din   = d;
        re    = r;
        raddr = {ra1, ra0};
        for (int p = 0; p < 2; p++) begin
            if (r[p]) exp_do[p] = (w && (wa == ra[p])) ? d : mdl[ra[p]];
        end
        e.stb = 2'b00;
        if (w) begin
            if (wa == 5'd9)  begin exp_tap[0] = d; e.stb[0] = 1'b1; end
            if (wa == 5'd20) begin exp_tap[1] = d; e.stb[1] = 1'b1; end
            mdl[wa] = d;
        end
        e.dout = {exp_do[1], exp_do[0]};
        e.tap  = {exp_tap[1], exp_tap[0]};
        sb.push_back(e);
        @(posedge clk); #1;
        e = sb.pop_front();
        check_val("dout", dout, e.dout);
        check_val("tap_data", tap_data, e.tap);
        check_val("tap_stb", {62'b0, tap_stb}, {62'b0, e.stb});
        we = 1'b0;
        re = 2'b00;
    endtask

    task automatic do_reset(input int cyc);
        rst_n = 1'b0;
        we    = 1'b0;
        re    = 2'b00;
        repeat (cyc) begin @(posedge clk); #1; end
        check_val("rst_dout", dout, 64'h0);
        check_val("rst_tap_data", tap_data, 64'h0);
        check_val("rst_tap_stb", {62'b0, tap_stb}, 64'h0);
        check_val("rst_busy", {63'b0, busy}, 64'h0);
        exp_do[0]  = '0;
        exp_do[1]  = '0;
        exp_tap[0] = '0;
        exp_tap[1] = '0;
    endtask

    // Release reset and count busy cycles; abort_at>0 stops early so the
    // caller can re-assert reset mid-clear. Accesses are attempted during
    // clear (after addresses 2 and 9 have been zeroed) and must be ignored.
    task automatic wait_clear(input string tag, input int abort_at);
        int n = 0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        while (busy && n < 100) begin
            n++;
            check_val({tag, "_clr_dout"}, dout, 64'h0);
            check_val({tag, "_clr_stb"}, {62'b0, tap_stb}, 64'h0);
            if (abort_at > 0 && n == abort_at) return;
            if (n == 12) begin we = 1'b1; waddr = 5'd2; din = 32'hFFFF_0002; re = 2'b11; raddr = {5'd2, 5'd2}; end
            if (n == 13) begin we = 1'b1; waddr = 5'd9; din = 32'hFFFF_0009; end
            if (n == 14) begin we = 1'b0; re = 2'b00; end
            @(posedge clk); #1;
        end
        check_val({tag, "_busy_cycles"}, 64'(n), 64'd32);
        check_val({tag, "_tap_after"}, tap_data, 64'h0);
        for (int a = 0; a < 32; a++) mdl[a] = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        we    = 1'b0;
        re    = 2'b00;
        waddr = '0;
        raddr = '0;
        din   = '0;
        for (int a = 0; a < 32; a++) mdl[a] = '0;
        @(posedge clk); #1;

        do_reset(3);
        wait_clear("clr1", 0);

        // every address on both ports reads zero, first read in busy-fall cycle
        for (int a = 0; a < 32; a++) step(1'b0, 5'd0, 32'h0, 2'b11, 5'(a), 5'(31 - a));

        // bypass on both ports, then on port 0 only
        step(1'b1, 5'd3, 32'h0000_0033, 2'b00, 5'd0, 5'd0);
        step(1'b1, 5'd4, 32'h0000_0011, 2'b00, 5'd0, 5'd0);
        step(1'b1, 5'd7, 32'hDEAD_BEEF, 2'b11, 5'd7, 5'd7);
        step(1'b1, 5'd7, 32'hCAFE_F00D, 2'b11, 5'd7, 5'd3);
        step(1'b0, 5'd0, 32'h0,         2'b11, 5'd7, 5'd7);

        // hold: dout keeps its value while re is low
        step(1'b0, 5'd0, 32'h0,         2'b01, 5'd4, 5'd0);
        step(1'b1, 5'd4, 32'h0000_0022, 2'b00, 5'd4, 5'd4);
        step(1'b0, 5'd0, 32'h0,         2'b00, 5'd0, 5'd0);
        step(1'b0, 5'd0, 32'h0,         2'b10, 5'd0, 5'd4);

        // taps
        step(1'b1, 5'd9,  32'h0000_00A5, 2'b00, 5'd0, 5'd0);
        step(1'b1, 5'd20, 32'h0000_005A, 2'b00, 5'd0, 5'd0);
        step(1'b1, 5'd10, 32'h0000_0077, 2'b00, 5'd0, 5'd0);
        step(1'b0, 5'd0,  32'h0,         2'b11, 5'd9, 5'd20);
        step(1'b0, 5'd0,  32'h0,         2'b11, 5'd10, 5'd2);

        // random traffic against the model
        for (int i = 0; i < 40; i++) begin
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end

        // reset mid-clear restarts the full clear
        do_reset(2);
        wait_clear("clr2a", 13);
        do_reset(2);
        wait_clear("clr2b", 0);
        step(1'b0, 5'd0, 32'h0, 2'b11, 5'd4, 5'd7);
        step(1'b0, 5'd0, 32'h0, 2'b11, 5'd9, 5'd20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
